// File: rtl/aes_pipe_if.sv
// Streaming block port of the AES-128 pipeline: one plaintext in, one ciphertext out, per clock.
// Neither side can stall: the core samples plaintext on every rising edge and cypertext is always current.
interface aes_pipe_if;
    logic [127:0] plaintext;
    logic [127:0] cypertext;

    modport master (output plaintext, input cypertext);
    modport slave  (input plaintext, output cypertext);
endinterface

// File: rtl/aes_pipe.sv
// Fully unrolled AES-128 encryption pipeline: one block per clock, 10-cycle latency.
// Round keys are folded from the KEY parameter at elaboration; there are no key registers.
module aes_pipe #(
    parameter logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f
) (
    input  logic    CLK,
    input  logic    RST,
    aes_pipe_if.slave bus
);

    typedef logic [10:0][127:0] rk_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of a block sits at bits [127-8i -: 8]; row = i mod 4, column = i div 4.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Rcon is generated by repeated xtime, giving 01,02,04,...,80,1b,36.
    function automatic rk_t key_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_t         rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) begin
            w[i] = key[127-32*i -: 32];
        end
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return rk;
    endfunction

    rk_t                w_rk;
    logic [10:1][127:0] w_round;
    logic [9:0][127:0]  r_stage;
    logic [9:0]         r_valid;
    logic [127:0]       r_ct;

    assign w_rk = key_expand(KEY);

    for (genvar k = 1; k <= 10; k++) begin : g_round
        if (k < 10) begin : g_mid
            assign w_round[k] = mix_columns(shift_rows(sub_bytes(r_stage[k-1]))) ^ w_rk[k];
        end else begin : g_last
            assign w_round[k] = shift_rows(sub_bytes(r_stage[k-1])) ^ w_rk[k];
        end
    end

    // r_valid[9] marks that stage9 holds a block sampled after the last reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stage <= '0;
            r_valid <= '0;
            r_ct    <= '0;
        end else begin
            r_stage[0]   <= bus.plaintext ^ w_rk[0];
            r_stage[9:1] <= w_round[9:1];
            r_valid      <= {r_valid[8:0], 1'b1};
            r_ct         <= r_valid[9] ? w_round[10] : '0;
        end
    end

    assign bus.cypertext = r_ct;

endmodule

// File: tb/tb_aes_pipe.sv
// Bench for aes_pipe: three key variants against a GF(2^8)-derived AES-128 model, plus FIPS-197 literals.
module tb_aes_pipe;

    localparam logic [127:0] K0    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2    = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    aes_pipe_if bus0 ();
    aes_pipe_if bus1 ();
    aes_pipe_if bus2 ();

    aes_pipe #(.KEY(K0)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
    aes_pipe #(.KEY(K1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
    aes_pipe #(.KEY(K2)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v};
        return d[15-n -: 8];
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [4][4];
        logic [7:0]   u [4][4];
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    u[r][c] = sb[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rd < 10)
                        s[r][c] = gmul(8'h02, u[r][c]) ^ gmul(8'h03, u[(r+1)%4][c])
                                ^ u[(r+2)%4][c] ^ u[(r+3)%4][c];
                    else
                        s[r][c] = u[r][c];
                end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
        end
        out = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[127-8*(4*c+r) -: 8] = s[r][c];
        return out;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- scoreboard ----------------
    // Output after edge n is the cipher of the block from edge n-10, provided edges n-10..n saw no reset.
    logic [127:0] exp_q0 [$];
    logic [127:0] exp_q1 [$];
    logic [127:0] exp_q2 [$];
    int run_len = 0;
    bit armed   = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            exp_q0.delete();
            exp_q1.delete();
            exp_q2.delete();
            run_len = 0;
            armed   = 1'b1;
        end else begin
            run_len++;
            exp_q0.push_back(aes_ref(bus0.plaintext, K0));
            exp_q1.push_back(aes_ref(bus1.plaintext, K1));
            exp_q2.push_back(aes_ref(bus2.plaintext, K2));
            if (exp_q0.size() > 11) void'(exp_q0.pop_front());
            if (exp_q1.size() > 11) void'(exp_q1.pop_front());
            if (exp_q2.size() > 11) void'(exp_q2.pop_front());
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            check("model_dut0", bus0.cypertext, (run_len >= 11) ? exp_q0[0] : 128'h0);
            check("model_dut1", bus1.cypertext, (run_len >= 11) ? exp_q1[0] : 128'h0);
            check("model_dut2", bus2.cypertext, (run_len >= 11) ? exp_q2[0] : 128'h0);
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic [127:0] p0, input logic [127:0] p1,
                       input logic [127:0] p2, input logic rst);
        RST            = rst;
        bus0.plaintext = p0;
        bus1.plaintext = p1;
        bus2.plaintext = p2;
        @(posedge CLK);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        RST            = 1'b1;
        bus0.plaintext = '0;
        bus1.plaintext = '0;
        bus2.plaintext = '0;
        build_sbox();
        check("model_pin_c1", aes_ref(PT_C1, K0), CT_C1);
        check("model_pin_b",  aes_ref(PT_B, K1), CT_B);

        // Reset held for two edges, then a fresh pipeline fill.
        cyc(rnd128(), rnd128(), rnd128(), 1'b1);
        cyc(rnd128(), rnd128(), rnd128(), 1'b1);
        check("reset_dut0", bus0.cypertext, 128'h0);
        check("reset_dut1", bus1.cypertext, 128'h0);
        for (int i = 0; i <= 10; i++) begin
            if (i == 0) cyc(PT_C1, PT_B, rnd128(), 1'b0);
            else        cyc(rnd128(), rnd128(), rnd128(), 1'b0);
            if (i < 10) begin
                check("fill_zero_dut0", bus0.cypertext, 128'h0);
                check("fill_zero_dut1", bus1.cypertext, 128'h0);
            end else begin
                check("fips_c1", bus0.cypertext, CT_C1);
                check("fips_b",  bus1.cypertext, CT_B);
            end
        end

        // Streaming 1..4 then held.
        for (int i = 1; i <= 4; i++) cyc(128'(i), 128'(i), 128'(i), 1'b0);
        for (int i = 0; i < 14; i++) cyc(128'd4, 128'd4, 128'd4, 1'b0);

        // Mid-stream reset on a continuous C.1 / App. B stream.
        for (int i = 0; i < 12; i++) cyc(PT_C1, PT_B, PT_C1, 1'b0);
        cyc(PT_C1, PT_B, PT_C1, 1'b1);
        check("midrst_dut0", bus0.cypertext, 128'h0);
        for (int j = 1; j <= 11; j++) begin
            cyc(PT_C1, PT_B, PT_C1, 1'b0);
            if (j <= 10) begin
                check("midrst_zero_dut0", bus0.cypertext, 128'h0);
                check("midrst_zero_dut1", bus1.cypertext, 128'h0);
            end else begin
                check("midrst_c1", bus0.cypertext, CT_C1);
                check("midrst_b",  bus1.cypertext, CT_B);
            end
        end

        // Random regression on all three keys.
        for (int i = 0; i < 1000; i++) cyc(rnd128(), rnd128(), rnd128(), 1'b0);
        for (int i = 0; i < 12; i++) cyc(128'h0, 128'h0, 128'h0, 1'b0);

        // ---------------- report ----------------
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_pipe.md
# aes_pipe

Fully pipelined AES-128 encryption core with a fixed, elaboration-time key, accepting one 128-bit plaintext block every clock and producing one ciphertext block every clock after a 10-cycle fill. It sits on a streaming datapath as a throughput-oriented cipher engine. There is no handshake: every rising edge samples a new block.

## Interface
Parameters:
- KEY, 128'h000102030405060708090a0b0c0d0e0f, AES-128 cipher key; bits [127:120] are key byte 0.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; one clock, reset is synchronous and active-high.
- plaintext  input  128  block to encrypt; bits [127:120] are FIPS-197 input byte 0, bits [7:0] are byte 15.
- cypertext  output  128  encrypted block, same byte ordering; driven directly from a register.

## Operation
- Standard FIPS-197 AES-128 encryption:
  - initial AddRoundKey;
  - rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey;
  - round 10: no MixColumns.
- State is column-major. Byte i of the 128-bit word maps to row i mod 4, column i div 4.
- Round keys 0..10 come from the standard AES-128 key expansion of KEY (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36).
  - KEY is constant, so round keys are constant-folded logic with no key registers.
  - The schedule must be computed from KEY, not hardcoded, so parameter overrides work.
- S-box is the standard AES forward S-box, implemented as a combinational lookup function instantiated 16 times per round.
- MixColumns uses xtime (shift left 1; XOR 0x1b if bit 7 was set). Columns are multiplied by the circulant matrix [02 03 01 01].
- Pipeline registers:
  - stage0 <= plaintext ^ rk0;
  - stage k (k=1..9) <= round_k(stage k-1);
  - output register <= round_10(stage9).
- Valid tracking: a 10-bit internal shift register, shifted in with 1 each non-reset cycle.
  - The output register loads round_10(stage9) only when the last valid bit is set; otherwise it holds 0.
- Reset (RST=1 at a rising edge) clears stage0..stage9, all valid bits and cypertext to 0.
  - Reset mid-stream discards all in-flight blocks.
  - Blocks sampled on the reset edge itself are discarded.

## Timing
- Reset value of cypertext: 128'h0.
- Latency is 10 clocks. A block sampled at rising edge t (RST=0) appears on cypertext immediately after edge t+10 and stays until edge t+11.
- Throughput: 1 block/clock, with no bubbles and no stall capability.
- After reset deasserts, the first edge with RST=0 is t0. cypertext stays 0 after edges t0..t0+9 and shows the first ciphertext after edge t0+10.
- Back-to-back distinct blocks produce back-to-back ciphertexts in the same order, one per clock.
- Holding plaintext constant produces a constant cypertext once the pipeline is full.
- No combinational path from any input to cypertext.

## Test plan
- Reset check: assert RST for 2 edges -> cypertext == 0. It remains 0 for the 10 edges after deassert, independent of plaintext.
- FIPS-197 C.1: default KEY, plaintext 00112233445566778899aabbccddeeff sampled at edge t -> cypertext 69c4e0d86a7b0430d8cdb78070b4c55a after edge t+10, and not before.
- FIPS-197 App. B: KEY=2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32 after 10 clocks.
- Streaming: plaintext 1, 2, 3, 4 on consecutive edges (default KEY), then held -> four distinct ciphertexts on consecutive cycles in order, each matching a software AES-128 model, then the ciphertext of 4 held steady.
- Mid-stream reset: stream the C.1 block continuously, assert RST for one edge -> cypertext 0 on the next cycle and for 10 further cycles, then 69c4e0d86a7b0430d8cdb78070b4c55a again.
- Random regression: 1000 random plaintexts, one per clock, with default and one random KEY -> every output equals the reference AES-128 result, delayed exactly 10 clocks.
